// File: rtl/wentansu_counter.sv
// wentansu_counter
//   8-bit up/down counter with a loadable count and a programmable wrap
//   limit, sitting directly behind the TinyTapeout tile pin interface.
//
// Ports
//   clk     in   1  clock, all state changes on the rising edge
//   rst_n   in   1  synchronous active-low reset (count=0x00, limit=0xFF)
//   ena     in   1  tile-selected indicator, not used by the logic
//   ui_in   in   8  [0] count_en [1] load [2] dir (1=up) [3] show_limit
//                   [4] set_limit, [7:5] unused
//   uio_in  in   8  data for load and set_limit
//   uo_out  out  8  count, or limit when show_limit=1
//   uio_out out  8  always 0x00
//   uio_oe  out  8  always 0x00 (bidirectional pins stay inputs)
module wentansu_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       count_en;
  logic       load;
  logic       dir;
  logic       show_limit;
  logic       set_limit;

  logic [7:0] count_reg;
  logic [7:0] count_next;
  logic [7:0] limit_reg;
  logic [7:0] limit_next;

  assign count_en   = ui_in[0];
  assign load       = ui_in[1];
  assign dir        = ui_in[2];
  assign show_limit = ui_in[3];
  assign set_limit  = ui_in[4];

  // Pins that exist on the tile but carry no function here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, ui_in[7:5]};

  // Wrap decisions use the limit held before the edge; a limit written in
  // the same cycle only matters from the next cycle onwards.
  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = uio_in;
    end else if (count_en) begin
      if (dir) begin
        // ">=" so a loaded value above the limit wraps on the next up step.
        if (count_reg >= limit_reg) begin
          count_next = 8'h00;
        end else begin
          count_next = count_reg + 8'd1;
        end
      end else begin
        if (count_reg == 8'h00) begin
          count_next = limit_reg;
        end else begin
          count_next = count_reg - 8'd1;
        end
      end
    end
  end

  always_comb begin
    limit_next = limit_reg;
    if (set_limit) begin
      limit_next = uio_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= 8'h00;
      limit_reg <= 8'hFF;
    end else begin
      count_reg <= count_next;
      limit_reg <= limit_next;
    end
  end

  assign uo_out  = show_limit ? limit_reg : count_reg;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_wentansu_counter.sv
module tb_wentansu_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic       count_en;
  logic       load;
  logic       dir;
  logic       show_limit;
  logic       set_limit;
  logic [2:0] spare;
  logic [7:0] ui_in;

  int n_checks = 0;
  int n_fail   = 0;

  assign ui_in = {spare, set_limit, show_limit, dir, load, count_en};

  always #5 clk = ~clk;

  wentansu_counter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%02h", tag, obs);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Look at the limit combinationally, then restore the count view.
  task automatic check_limit(input string tag, input logic [7:0] exp);
    show_limit = 1'b1;
    #1;
    check(tag, uo_out, exp);
    show_limit = 1'b0;
    #1;
  endtask

  task automatic check_tie(input string tag);
    check({tag, "_uio_out"}, uio_out, 8'h00);
    check({tag, "_uio_oe"}, uio_oe, 8'h00);
  endtask

  logic [7:0] exp_up2 [8]   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h01, 8'h02};
  logic [7:0] exp_down2 [4] = '{8'h01, 8'h00, 8'h05, 8'h04};
  logic [7:0] exp_lim0 [4]  = '{8'h02, 8'h01, 8'h00, 8'h00};

  initial begin
    rst_n = 1'b0; ena = 1'b1; uio_in = 8'h00;
    count_en = 1'b0; load = 1'b0; dir = 1'b0;
    show_limit = 1'b0; set_limit = 1'b0; spare = 3'b000;

    // 1. reset, then free-running up count with limit 0xFF
    #2;
    tick();
    tick();
    check("reset_count", uo_out, 8'h00);
    check_limit("reset_limit", 8'hFF);
    check_tie("reset");
    rst_n = 1'b1;
    count_en = 1'b1; dir = 1'b1;
    #1;
    check("up256_0", uo_out, 8'h00);
    for (int i = 1; i < 260; i++) begin
      tick();
      check($sformatf("up256_%0d", i), uo_out, 8'(i));
    end
    check_limit("up256_limit", 8'hFF);

    // 2. limit 5: clear count and set limit together, then up and down
    count_en = 1'b0; load = 1'b1; set_limit = 1'b1; uio_in = 8'h05;
    tick();
    check("lim5_load_count", uo_out, 8'h05);
    load = 1'b1; set_limit = 1'b0; uio_in = 8'h00;
    tick();
    check("lim5_start", uo_out, 8'h00);
    check_limit("lim5_limit", 8'h05);
    load = 1'b0; count_en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("lim5_up_%0d", i), uo_out, exp_up2[i]);
    end
    dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("lim5_down_%0d", i), uo_out, exp_down2[i]);
    end

    // 3. load beats count_en; value above limit wraps on next up step
    load = 1'b1; count_en = 1'b1; dir = 1'b1; uio_in = 8'hA0;
    tick();
    check("load_beats_en", uo_out, 8'hA0);
    load = 1'b0;
    tick();
    check("above_limit_wrap", uo_out, 8'h00);

    // 4. load and set_limit in the same cycle; old limit 5 still used there
    count_en = 1'b1; load = 1'b1; set_limit = 1'b1; uio_in = 8'h03;
    tick();
    check("ld_sl_count", uo_out, 8'h03);
    check_limit("ld_sl_limit", 8'h03);
    load = 1'b0; set_limit = 1'b0;
    tick();
    check("ld_sl_wrap", uo_out, 8'h00);
    tick();
    check("ld_sl_next", uo_out, 8'h01);

    // limit 0 boundary cases
    count_en = 1'b0; set_limit = 1'b1; uio_in = 8'h00;
    tick();
    set_limit = 1'b0; count_en = 1'b1; dir = 1'b1;
    tick();
    check("lim0_up_a", uo_out, 8'h00);
    tick();
    check("lim0_up_b", uo_out, 8'h00);
    dir = 1'b0;
    tick();
    check("lim0_down_zero", uo_out, 8'h00);
    load = 1'b1; uio_in = 8'h03;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("lim0_down_%0d", i), uo_out, exp_lim0[i]);
    end

    // 5. limit 0xFF: down wraps to 0xFF; count to 0x42 then reset over load
    count_en = 1'b0; set_limit = 1'b1; load = 1'b1; uio_in = 8'hFF;
    tick();
    set_limit = 1'b0; uio_in = 8'h00;
    tick();
    load = 1'b0; count_en = 1'b1; dir = 1'b0;
    tick();
    check("ff_down_wrap", uo_out, 8'hFF);
    load = 1'b1; count_en = 1'b0; uio_in = 8'h40;
    tick();
    load = 1'b0; count_en = 1'b1; dir = 1'b1;
    tick();
    tick();
    check("pre_reset_42", uo_out, 8'h42);
    check_tie("pre_reset");
    rst_n = 1'b0; load = 1'b1; set_limit = 1'b1; uio_in = 8'h77;
    tick();
    check("mid_reset_count", uo_out, 8'h00);
    check_limit("mid_reset_limit", 8'hFF);
    check_tie("mid_reset");
    rst_n = 1'b1; load = 1'b0; set_limit = 1'b0; count_en = 1'b0;

    // 6. hold: count_en=0 with other inputs toggling
    load = 1'b1; uio_in = 8'h5A;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dir = i[0]; ena = i[1]; spare = 3'(i * 5);
      uio_in = 8'(i * 37);
      tick();
      check($sformatf("hold_%0d", i), uo_out, 8'h5A);
    end
    check_tie("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
